// File: rtl/mem_stage_if.sv
// D-cache request/response bus between the memory stage (master) and the data cache (slave).
interface mem_stage_if #(
    parameter int BIT_W = 32
);
    logic             mem_cen;
    logic             mem_wen;
    logic [BIT_W-3:0] mem_addr;
    logic [BIT_W-1:0] mem_wdata;
    logic [BIT_W-1:0] mem_rdata;
    logic             mem_stall;

    modport master (
        output mem_cen, mem_wen, mem_addr, mem_wdata,
        input  mem_rdata, mem_stall
    );

    modport slave (
        input  mem_cen, mem_wen, mem_addr, mem_wdata,
        output mem_rdata, mem_stall
    );
endinterface

// File: rtl/mem_stage.sv
// Memory pipeline stage: D-cache handshake, stall request, writeback select and MEM/WB register.
//  state | meaning
//  IDLE  | no access outstanding; a new access is issued combinationally
//  WAIT  | access issued, cache busy; keep requesting until it completes
//  HOLD  | access completed while the pipeline was stalled; data parked in hold_buf
module mem_stage #(
    parameter int BIT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [BIT_W-1:0] alu_result_in,
    input  logic [BIT_W-1:0] mem_wdata_in,
    input  logic [4:0]       rd_in,
    input  logic [BIT_W-1:0] PC_step_in,
    input  logic             memrd_in,
    input  logic             memwr_in,
    input  logic             mem2reg_in,
    input  logic             regwr_in,
    input  logic             jump_in,
    input  logic             mul_ppl_in,
    input  logic [BIT_W-1:0] mul_result_in,
    input  logic             stall_in,
    mem_stage_if.master      dmem,
    output logic             mem_busy,
    output logic [4:0]       fwd_rd,
    output logic             fwd_regwr,
    output logic             fwd_load,
    output logic [BIT_W-1:0] fwd_dat,
    output logic [4:0]       wb_rd,
    output logic             wb_regwr,
    output logic [BIT_W-1:0] wb_data
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic             access;
    logic             advance;
    logic             complete;
    logic             cen;
    logic             wen;
    logic [BIT_W-1:0] hold_buf;
    logic [BIT_W-1:0] load_data;
    logic [BIT_W-1:0] wb_next;

    assign access = memrd_in | memwr_in;

    always_comb begin
        cen = 1'b0;
        wen = 1'b0;
        case (state)
            S_IDLE: begin
                cen = access;
                wen = memwr_in;
            end
            S_WAIT: begin
                cen = 1'b1;
                wen = memwr_in;
            end
            default: begin
                cen = 1'b0;
                wen = 1'b0;
            end
        endcase
    end

    assign dmem.mem_cen   = cen;
    assign dmem.mem_wen   = wen;
    assign dmem.mem_addr  = alu_result_in[BIT_W-1:2];
    assign dmem.mem_wdata = mem_wdata_in;

    assign mem_busy = (state != S_HOLD) & access & dmem.mem_stall;
    assign advance  = ~stall_in & ~mem_busy;
    assign complete = cen & ~dmem.mem_stall;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (complete && stall_in)
                    state_nxt = S_HOLD;
                else if (access && dmem.mem_stall)
                    state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (complete)
                    state_nxt = stall_in ? S_HOLD : S_IDLE;
            end
            S_HOLD: begin
                if (!stall_in)
                    state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state    <= S_IDLE;
            hold_buf <= '0;
        end else begin
            state <= state_nxt;
            if (state != S_HOLD && state_nxt == S_HOLD)
                hold_buf <= dmem.mem_rdata;
        end
    end

    // Once parked, the cache bus may carry unrelated data, so loads read the buffer.
    assign load_data = (state == S_HOLD) ? hold_buf : dmem.mem_rdata;

    always_comb begin
        if (mem2reg_in)
            wb_next = load_data;
        else if (mul_ppl_in)
            wb_next = mul_result_in;
        else if (jump_in)
            wb_next = PC_step_in;
        else
            wb_next = alu_result_in;
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            wb_rd    <= '0;
            wb_regwr <= 1'b0;
            wb_data  <= '0;
        end else if (advance) begin
            wb_rd    <= rd_in;
            wb_regwr <= regwr_in;
            wb_data  <= wb_next;
        end
    end

    assign fwd_rd    = rd_in;
    assign fwd_regwr = regwr_in;
    assign fwd_load  = mem2reg_in;
    assign fwd_dat   = jump_in    ? PC_step_in :
                       mul_ppl_in ? mul_result_in : alu_result_in;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: per-cycle compare against an instruction-level model plus literal checks.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] alu_result_in, mem_wdata_in, PC_step_in, mul_result_in;
    logic [4:0]  rd_in;
    logic        memrd_in, memwr_in, mem2reg_in, regwr_in, jump_in, mul_ppl_in, stall_in;
    logic        mem_busy, fwd_regwr, fwd_load, wb_regwr;
    logic [4:0]  fwd_rd, wb_rd;
    logic [31:0] fwd_dat, wb_data;

    mem_stage_if #(.BIT_W(32)) dmem ();

    mem_stage #(.BIT_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_result_in(alu_result_in), .mem_wdata_in(mem_wdata_in), .rd_in(rd_in),
        .PC_step_in(PC_step_in), .memrd_in(memrd_in), .memwr_in(memwr_in),
        .mem2reg_in(mem2reg_in), .regwr_in(regwr_in), .jump_in(jump_in),
        .mul_ppl_in(mul_ppl_in), .mul_result_in(mul_result_in), .stall_in(stall_in),
        .dmem(dmem), .mem_busy(mem_busy),
        .fwd_rd(fwd_rd), .fwd_regwr(fwd_regwr), .fwd_load(fwd_load), .fwd_dat(fwd_dat),
        .wb_rd(wb_rd), .wb_regwr(wb_regwr), .wb_data(wb_data)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int n_cen = 0;
    int n_done = 0;
    logic cmp_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Instruction-level model: an instruction either retires, or has already
    // received its cache data and is waiting out an external stall.
    logic        m_got;
    logic [31:0] m_buf;
    logic [4:0]  m_rd;
    logic        m_regwr;
    logic [31:0] m_wb;

    function automatic logic [31:0] wb_pick(input logic [31:0] ld);
        if (mem2reg_in)      return ld;
        else if (mul_ppl_in) return mul_result_in;
        else if (jump_in)    return PC_step_in;
        else                 return alu_result_in;
    endfunction

    always @(posedge clk or posedge rst_n) begin
        logic acc, busy;
        if (rst_n) begin
            m_got = 1'b0; m_buf = '0; m_rd = '0; m_regwr = 1'b0; m_wb = '0;
        end else begin
            acc  = memrd_in | memwr_in;
            busy = acc & ~m_got & dmem.mem_stall;
            if (!stall_in && !busy) begin
                m_rd    = rd_in;
                m_regwr = regwr_in;
                m_wb    = wb_pick(m_got ? m_buf : dmem.mem_rdata);
                m_got   = 1'b0;
            end else if (acc && !m_got && !dmem.mem_stall) begin
                m_got = 1'b1;
                m_buf = dmem.mem_rdata;
            end
        end
    end

    always @(negedge clk) begin
        logic acc;
        logic [31:0] e_fwd;
        if (dmem.mem_cen) n_cen++;
        if (dmem.mem_cen && !dmem.mem_stall) n_done++;
        if (cmp_en) begin
            acc   = memrd_in | memwr_in;
            e_fwd = jump_in ? PC_step_in : (mul_ppl_in ? mul_result_in : alu_result_in);
            chk("m_cen",   32'(dmem.mem_cen),  32'(acc & ~m_got));
            chk("m_wen",   32'(dmem.mem_wen),  32'(memwr_in & ~m_got));
            chk("m_busy",  32'(mem_busy),      32'(acc & ~m_got & dmem.mem_stall));
            chk("m_addr",  32'(dmem.mem_addr), {2'b00, alu_result_in[31:2]});
            chk("m_wdata", dmem.mem_wdata,     mem_wdata_in);
            chk("m_fwd",   fwd_dat,            e_fwd);
            chk("m_fwdrd", {27'd0, fwd_rd, fwd_regwr, fwd_load} >> 0,
                           {27'd0, rd_in, regwr_in, mem2reg_in} >> 0);
            chk("m_wbrd",  32'(wb_rd),         32'(m_rd));
            chk("m_wbrw",  32'(wb_regwr),      32'(m_regwr));
            chk("m_wbdat", wb_data,            m_wb);
        end
    end

    task automatic clr();
        alu_result_in = '0; mem_wdata_in = '0; PC_step_in = '0; mul_result_in = '0;
        rd_in = '0; memrd_in = 0; memwr_in = 0; mem2reg_in = 0; regwr_in = 0;
        jump_in = 0; mul_ppl_in = 0; stall_in = 0;
        dmem.mem_stall = 0; dmem.mem_rdata = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, d0;
        clr();
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_wbdat", wb_data, 32'h0);
        chk("rst_cen", 32'(dmem.mem_cen), 32'h0);
        rst_n = 1'b0;
        cmp_en = 1'b1;

        // 1: plain ALU op
        alu_result_in = 32'h1234; regwr_in = 1; rd_in = 5;
        #1 chk("alu_cen", 32'(dmem.mem_cen), 32'h0);
        tick();
        chk("alu_wbrd", 32'(wb_rd), 32'd5);
        chk("alu_wbdat", wb_data, 32'h1234);
        clr();

        // 2: load hit
        c0 = n_cen;
        memrd_in = 1; mem2reg_in = 1; regwr_in = 1; rd_in = 7; alu_result_in = 32'h100;
        dmem.mem_rdata = 32'hDEADBEEF;
        #1;
        chk("hit_addr", 32'(dmem.mem_addr), 32'h40);
        chk("hit_cen", 32'(dmem.mem_cen), 32'h1);
        chk("hit_busy", 32'(mem_busy), 32'h0);
        tick();
        clr();
        chk("hit_wbdat", wb_data, 32'hDEADBEEF);
        #1 chk("hit_ncen", 32'(n_cen - c0), 32'd1);

        // 3: load miss, three busy cycles
        memrd_in = 1; mem2reg_in = 1; regwr_in = 1; rd_in = 9; alu_result_in = 32'h200;
        dmem.mem_stall = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("miss_busy", 32'(mem_busy), 32'h1);
            chk("miss_wbhold", wb_data, 32'hDEADBEEF);
            tick();
        end
        dmem.mem_stall = 0; dmem.mem_rdata = 32'h55AA1234;
        #1 chk("miss_busy4", 32'(mem_busy), 32'h0);
        tick();
        chk("miss_wbdat", wb_data, 32'h55AA1234);
        chk("miss_wbrd", 32'(wb_rd), 32'd9);
        clr();
        #1 chk("miss_idle", 32'(dmem.mem_cen), 32'h0);

        // 4: completion under external stall
        c0 = n_cen; d0 = n_done;
        memrd_in = 1; mem2reg_in = 1; regwr_in = 1; rd_in = 10; alu_result_in = 32'h300;
        dmem.mem_rdata = 32'hCAFE0001; stall_in = 1;
        #1 chk("hold_cen0", 32'(dmem.mem_cen), 32'h1);
        tick();
        dmem.mem_rdata = 32'hBAD0BAD0;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("hold_cen", 32'(dmem.mem_cen), 32'h0);
            chk("hold_wbkeep", wb_data, 32'h55AA1234);
            tick();
        end
        stall_in = 0;
        tick();
        clr();
        chk("hold_wbdat", wb_data, 32'hCAFE0001);
        chk("hold_wbrd", 32'(wb_rd), 32'd10);
        #1;
        chk("hold_ncen", 32'(n_cen - c0), 32'd1);
        chk("hold_ndone", 32'(n_done - d0), 32'd1);

        // 5: jal link value, multiplier result, store hit
        jump_in = 1; PC_step_in = 32'h84; alu_result_in = 32'h200; regwr_in = 1; rd_in = 1;
        #1 chk("jal_fwd", fwd_dat, 32'h84);
        tick();
        chk("jal_wbdat", wb_data, 32'h84);
        jump_in = 0; mul_ppl_in = 1; mul_result_in = 32'h3C; rd_in = 2;
        #1 chk("mul_fwd", fwd_dat, 32'h3C);
        tick();
        chk("mul_wbdat", wb_data, 32'h3C);
        clr();
        memwr_in = 1; mem_wdata_in = 32'h77; alu_result_in = 32'h500; rd_in = 3;
        #1;
        chk("st_wen", 32'(dmem.mem_wen), 32'h1);
        chk("st_wdata", dmem.mem_wdata, 32'h77);
        tick();
        chk("st_wbrw", 32'(wb_regwr), 32'h0);
        clr();

        // 6: store miss, reset asserted mid-WAIT
        memwr_in = 1; mem_wdata_in = 32'h99; alu_result_in = 32'h400; regwr_in = 0; rd_in = 4;
        dmem.mem_stall = 1;
        tick();
        chk("rwait_busy", 32'(mem_busy), 32'h1);
        #2;
        rst_n = 1'b1;
        clr();
        #1;
        chk("rst6_cen", 32'(dmem.mem_cen), 32'h0);
        chk("rst6_busy", 32'(mem_busy), 32'h0);
        chk("rst6_wbdat", wb_data, 32'h0);
        chk("rst6_wbrd", 32'(wb_rd), 32'h0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk("rst6_idle", 32'(dmem.mem_cen), 32'h0);
        tick();
        alu_result_in = 32'h42; regwr_in = 1; rd_in = 6;
        tick();
        chk("post_wbdat", wb_data, 32'h42);
        clr();
        tick();

        cmp_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Pipeline stage directly downstream of the execute stage. Consumes the EX/MEM register outputs: ALU result, store data, rd, PC+step and control bits.
- Runs the data-cache request/response handshake and raises a pipeline stall while the cache is busy.
- Selects the writeback value and drives the MEM/WB register.
- Provides an unregistered forwarding source for the forwarding and hazard units.

Parameters:
- BIT_W, 32, datapath width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset; asynchronous, active-high (asserted = 1).
- alu_result_in  in  BIT_W  address or ALU value from execute.
- mem_wdata_in  in  BIT_W  store data.
- rd_in  in  5  destination register.
- PC_step_in  in  BIT_W  PC+2/+4, link value for jumps.
- memrd_in  in  1  load.
- memwr_in  in  1  store.
- mem2reg_in  in  1  writeback selects load data.
- regwr_in  in  1  register write enable.
- jump_in  in  1  jal/jalr; writeback selects PC_step_in.
- mul_ppl_in  in  1  writeback selects mul_result_in.
- mul_result_in  in  BIT_W  multiplier pipeline result aligned to this stage.
- stall_in  in  1  global stall from other sources (e.g. I-cache).
- mem_cen  out  1  D-cache request.
- mem_wen  out  1  D-cache write.
- mem_addr  out  BIT_W-2  word address = alu_result_in[BIT_W-1:2].
- mem_wdata  out  BIT_W  = mem_wdata_in.
- mem_rdata  in  BIT_W  D-cache read data; valid in the completion cycle.
- mem_stall  in  1  D-cache busy.
- mem_busy  out  1  stall request to the hazard unit; unregistered.
- fwd_rd  out  5  = rd_in; unregistered.
- fwd_regwr  out  1  = regwr_in; unregistered.
- fwd_load  out  1  = mem2reg_in; fwd_dat is not valid when this is set.
- fwd_dat  out  BIT_W  unregistered forwarding value: jump ? PC_step_in : mul_ppl_in ? mul_result_in : alu_result_in.
- wb_rd  out  5  MEM/WB register.
- wb_regwr  out  1  MEM/WB register.
- wb_data  out  BIT_W  MEM/WB register.

Behaviour:
- Definitions:
  - access = memrd_in | memwr_in.
  - advance = !stall_in & !mem_busy.
  - complete = mem_cen & !mem_stall.
- State machine states: IDLE, WAIT, HOLD. The reset state is IDLE.
- IDLE:
  - mem_cen = access; mem_wen = memwr_in.
  - complete & advance: stay IDLE.
  - complete & stall_in: go HOLD.
  - access & mem_stall: go WAIT.
- WAIT:
  - mem_cen = 1; mem_wen = memwr_in.
  - complete & advance: go IDLE.
  - complete & stall_in: go HOLD.
  - Otherwise stay WAIT.
- HOLD:
  - mem_cen = 0, so the access is never reissued.
  - Leave to IDLE on the first cycle with !stall_in.
- mem_busy = (state != HOLD) & access & mem_stall.
- Hold buffer: on entry to HOLD, latch mem_rdata into it. In HOLD, load data is taken from the buffer.
- Writeback value: wb_next = mem2reg_in ? load data : mul_ppl_in ? mul_result_in : jump_in ? PC_step_in : alu_result_in.
  - Load data = mem_rdata in IDLE/WAIT, the hold buffer in HOLD.
- MEM/WB register update:
  - wb_rd, wb_regwr and wb_data capture rd_in, regwr_in and wb_next on the clock edge where advance = 1.
  - Otherwise they hold their value.
- Stores: wb_regwr follows regwr_in (0 for stores).
- Load latency: rdata is registered into wb_data on the completion edge. A zero-wait-state hit completes in the first cycle with mem_cen = 1.
- Simultaneous cache completion and stall_in: data is preserved in HOLD and wb is written only once, when stall_in drops.
- Reset:
  - Async assert drives wb_rd = 0, wb_regwr = 0, wb_data = 0, hold buffer = 0, state = IDLE.
  - mem_cen follows combinationally. An in-flight access is abandoned; the cache must tolerate cen dropping.
- Unregistered outputs are valid whenever the inputs are. Port widths are fixed; there is no arithmetic beyond selection.

Test Plan:
1. ALU op: alu_result_in = 0x1234, regwr_in = 1, rd_in = 5, no stall -> next edge wb_rd = 5, wb_data = 0x1234, mem_cen = 0 throughout.
2. Load hit: memrd_in = mem2reg_in = 1, alu_result_in = 0x100, mem_stall = 0, mem_rdata = 0xDEADBEEF -> mem_addr = 0x40, mem_cen = 1 for one cycle, wb_data = 0xDEADBEEF, mem_busy = 0.
3. Load miss: mem_stall high for 3 cycles -> mem_busy = 1 for 3 cycles, wb unchanged; on the 4th cycle wb_data = mem_rdata and state returns to IDLE.
4. Completion during stall_in = 1 (held 2 extra cycles) -> HOLD entered, mem_cen = 0, rdata 0xCAFE0001 buffered, wb_data = 0xCAFE0001 on the edge after stall_in drops; exactly one cache request.
5. jal with PC_step_in = 0x84, alu_result_in = 0x200 -> fwd_dat = 0x84, wb_data = 0x84; mul_ppl_in = 1 with mul_result_in = 0x3C -> wb_data = 0x3C.
6. Store miss with reset asserted mid-WAIT -> mem_cen and mem_busy = 0 immediately, wb outputs = 0, IDLE after release.
